// File: rtl/store_merge_unit.sv
// store_merge_unit: performs sw/sh/sb stores against a word-wide memory.
// Aligned words are written directly. Halfwords and bytes read the
// containing word, merge the new lane(s) into it, then write it back.
// Misaligned stores and the reserved type complete with fault and no write.
// All outputs come straight from registers.
module store_merge_unit #(
  parameter int READ_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, MERGE, WRITE, DONE} state_t;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;
  localparam logic [1:0] ST_RS = 2'b11;
  localparam logic [2:0] RW_LAST = 3'(READ_WAIT - 1);

  state_t      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [1:0]  lane_q, lane_d;     // addr[1:0] of the accepted store
  logic [15:0] data_q, data_d;     // only the low half is ever merged
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        reject;
  logic [31:0] merged;

  // Rejection decision for the store being offered in IDLE
  always_comb begin
    reject = (store_type == ST_RS) ||
             (store_type == ST_SW && addr[1:0] != 2'b00) ||
             (store_type == ST_SH && addr[0]);
  end

  // Lane merge of the captured memory word with the latched source data
  always_comb begin
    merged = merge_q;
    if (type_q == ST_SB) begin
      case (lane_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = data_q;
    end else begin
      merged[15:0] = data_q;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    lane_d      = lane_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    merge_d     = merge_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          type_d     = store_type;
          lane_d     = addr[1:0];
          data_d     = reg_data[15:0];
          mem_addr_d = {addr[31:2], 2'b00};
          if (reject) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else if (store_type == ST_SW) begin
            state_d     = WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = reg_data;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = RW_LAST;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          merge_d = mem_rdata;
          state_d = MERGE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      MERGE: begin
        state_d     = WRITE;
        mem_wr_d    = 1'b1;
        mem_wdata_d = merged;
      end
      WRITE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      type_q      <= ST_SW;
      lane_q      <= 2'b00;
      data_q      <= 16'h0;
      cnt_q       <= 3'd0;
      merge_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      lane_q      <= lane_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      merge_q     <= merge_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with READ_WAIT=2.
// Latency counts the edge at which done is seen high: 1 = the edge right
// after the accepting edge.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  store_type = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] reg_data = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wr, busy, done, fault;

  int total = 0;
  int bad   = 0;

  store_merge_unit #(.READ_WAIT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .store_type(store_type),
    .addr(addr), .reg_data(reg_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  // Drives one store from a negedge and observes it until done (bounded).
  // Returns at a negedge, one cycle after done, with start low.
  task automatic do_store(input logic [1:0] t, input logic [31:0] a, d, rd,
                          input bit hold, output int wr_n,
                          output logic [31:0] wa, wd, output int lat,
                          output logic flt, output logic idle_after);
    wr_n = 0; wa = 32'h0; wd = 32'h0; lat = -1; flt = 1'b0;
    store_type = t; addr = a; reg_data = d; mem_rdata = rd; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (mem_wr) begin wr_n++; wa = mem_addr; wd = mem_wdata; end
      if (done) begin lat = n; flt = fault; break; end
    end
    @(negedge clk);
    idle_after = !busy && !done && !mem_wr;
    start = 1'b0;
  endtask

  task automatic test_reset();
    int w, l; logic [31:0] wa, wd; logic f, ia;
    reset = 1'b0; start = 1'b1; store_type = 2'b00; reg_data = 32'h12345678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, fault, mem_wr, mem_addr, mem_wdata} !== 68'h0) begin
      bad++; $display("FAIL reset_outputs got b=%b d=%b f=%b w=%b a=%h wd=%h want all 0",
                      busy, done, fault, mem_wr, mem_addr, mem_wdata);
    end
    // first edge with reset high accepts
    reset = 1'b1;
    do_store(2'b00, 32'h40, 32'h0BADF00D, 32'h0, 1'b0, w, wa, wd, l, f, ia);
    total++;
    if (l !== 2 || w !== 1 || wd !== 32'h0BADF00D) begin
      bad++; $display("FAIL reset_first_start got lat=%0d wr=%0d wd=%h want 2 1 0badf00d", l, w, wd);
    end
  endtask

  task automatic test_sw();
    int w, l; logic [31:0] wa, wd; logic f, ia;
    do_store(2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, w, wa, wd, l, f, ia);
    total++;
    if (w !== 1 || wa !== 32'h100 || wd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_write got wr=%0d a=%h d=%h want 1 100 deadbeef", w, wa, wd);
    end
    total++;
    if (l !== 2 || f !== 1'b0 || ia !== 1'b1) begin
      bad++; $display("FAIL sw_timing got lat=%0d fault=%b idle=%b want 2 0 1", l, f, ia);
    end
    total++;
    if (mem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_wdata_hold got %h want deadbeef", mem_wdata);
    end
  endtask

  task automatic test_sb();
    int w, l; logic [31:0] wa, wd; logic f, ia;
    logic [31:0] av [4]; logic [31:0] dv [4]; logic [31:0] rv [4]; logic [31:0] ev [4];
    av = '{32'h102, 32'h0, 32'h401, 32'h303};
    dv = '{32'hFFFFFFAB, 32'h00000077, 32'h00000099, 32'h0000005A};
    rv = '{32'h11223344, 32'hFFFFFFFF, 32'h00000000, 32'h11223344};
    ev = '{32'h11AB3344, 32'hFFFFFF77, 32'h00009900, 32'h5A223344};
    for (int i = 0; i < 4; i++) begin
      do_store(2'b10, av[i], dv[i], rv[i], 1'b0, w, wa, wd, l, f, ia);
      total++;
      if (w !== 1 || wa !== {av[i][31:2], 2'b00} || wd !== ev[i] || l !== 5 || f !== 1'b0) begin
        bad++; $display("FAIL sb_%0d got wr=%0d a=%h d=%h lat=%0d f=%b want 1 %h %h 5 0",
                        i, w, wa, wd, l, f, {av[i][31:2], 2'b00}, ev[i]);
      end
    end
  endtask

  task automatic test_sh();
    int w, l; logic [31:0] wa, wd; logic f, ia;
    do_store(2'b01, 32'h206, 32'h0000CAFE, 32'h55667788, 1'b0, w, wa, wd, l, f, ia);
    total++;
    if (w !== 1 || wa !== 32'h204 || wd !== 32'hCAFE7788 || l !== 5 || f !== 1'b0) begin
      bad++; $display("FAIL sh_upper got wr=%0d a=%h d=%h lat=%0d f=%b want 1 204 cafe7788 5 0", w, wa, wd, l, f);
    end
    do_store(2'b01, 32'h200, 32'hFFFF1234, 32'hAABBCCDD, 1'b0, w, wa, wd, l, f, ia);
    total++;
    if (w !== 1 || wa !== 32'h200 || wd !== 32'hAABB1234 || l !== 5) begin
      bad++; $display("FAIL sh_lower got wr=%0d a=%h d=%h lat=%0d want 1 200 aabb1234 5", w, wa, wd, l);
    end
  endtask

  task automatic test_fault();
    int w, l; logic [31:0] wa, wd; logic f, ia;
    logic [1:0] tv [4]; logic [31:0] av [4];
    tv = '{2'b01, 2'b00, 2'b11, 2'b11};
    av = '{32'h201, 32'h102, 32'h100, 32'h333};
    for (int i = 0; i < 4; i++) begin
      do_store(tv[i], av[i], 32'h87654321, 32'h0, 1'b0, w, wa, wd, l, f, ia);
      total++;
      if (w !== 0 || l !== 1 || f !== 1'b1 || ia !== 1'b1) begin
        bad++; $display("FAIL fault_%0d got wr=%0d lat=%0d f=%b idle=%b want 0 1 1 1", i, w, l, f, ia);
      end
    end
    total++;
    if (mem_wdata !== 32'hAABB1234) begin
      bad++; $display("FAIL fault_wdata_hold got %h want aabb1234", mem_wdata);
    end
  endtask

  // start held high for the whole store, including the DONE cycle
  task automatic test_busy_start();
    int w, l, extra; logic [31:0] wa, wd; logic f, ia;
    do_store(2'b10, 32'h501, 32'h000000C3, 32'h01020304, 1'b1, w, wa, wd, l, f, ia);
    total++;
    if (w !== 1 || wd !== 32'h0102C304 || l !== 5 || ia !== 1'b1) begin
      bad++; $display("FAIL busy_start got wr=%0d d=%h lat=%0d idle=%b want 1 0102c304 5 1", w, wd, l, ia);
    end
    extra = 0;
    repeat (6) begin @(negedge clk); if (done || mem_wr || busy) extra++; end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL busy_extra_activity got %0d want 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int w, l, act; logic [31:0] wa, wd; logic f, ia;
    store_type = 2'b10; addr = 32'h102; reg_data = 32'hAB; mem_rdata = 32'h11223344;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, done, fault, mem_wr, mem_addr, mem_wdata} !== 68'h0) begin
      bad++; $display("FAIL abort_outputs got b=%b d=%b f=%b w=%b a=%h wd=%h want all 0",
                      busy, done, fault, mem_wr, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    act = 0;
    repeat (8) begin @(negedge clk); if (mem_wr || done || busy) act++; end
    total++;
    if (act !== 0) begin
      bad++; $display("FAIL abort_no_write got activity=%0d want 0", act);
    end
    do_store(2'b00, 32'h300, 32'hC0FFEE00, 32'h0, 1'b0, w, wa, wd, l, f, ia);
    total++;
    if (w !== 1 || wa !== 32'h300 || wd !== 32'hC0FFEE00 || l !== 2 || f !== 1'b0) begin
      bad++; $display("FAIL abort_then_sw got wr=%0d a=%h d=%h lat=%0d f=%b want 1 300 c0ffee00 2 0", w, wa, wd, l, f);
    end
  endtask

  // next start offered on the very negedge after done's cycle
  task automatic test_back_to_back();
    int w, l; logic [31:0] wa, wd; logic f, ia;
    do_store(2'b11, 32'h10, 32'h1, 32'h0, 1'b0, w, wa, wd, l, f, ia);
    do_store(2'b01, 32'h12, 32'h0000BEEF, 32'h99887766, 1'b0, w, wa, wd, l, f, ia);
    total++;
    if (w !== 1 || wa !== 32'h10 || wd !== 32'hBEEF7766 || l !== 5 || f !== 1'b0) begin
      bad++; $display("FAIL back_to_back got wr=%0d a=%h d=%h lat=%0d f=%b want 1 10 beef7766 5 0", w, wa, wd, l, f);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_fault();
    test_busy_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 Parameter READ_WAIT, default 2, memory read latency in cycles from address presented to mem_rdata valid (legal 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 store_type  input  2  00 word (sw), 01 halfword (sh), 10 byte (sb), 11 reserved.
REQ-006 addr  input  32  byte address of the store.
REQ-007 reg_data  input  32  source register value; sh uses [15:0], sb uses [7:0].
REQ-008 mem_rdata  input  32  word read from memory at mem_addr.
REQ-009 mem_addr  output  32  word-aligned address {addr_q[31:2],2'b00}.
REQ-010 mem_wdata  output  32  merged word to write.
REQ-011 mem_wr  output  1  memory write enable, one cycle per store.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 fault  output  1  valid with done; 1 = store rejected (misaligned or reserved type), no write issued.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-016 States SHALL be IDLE, RD_WAIT, MERGE, WRITE, DONE.
REQ-017 IDLE with start=1 SHALL latch store_type, addr and reg_data into internal registers, which hold for the whole operation.
REQ-018 start SHALL be ignored while busy=1; a start in the same cycle DONE returns to IDLE SHALL be ignored.
REQ-019 Fault check at acceptance: sw with addr[1:0]!=0, sh with addr[0]=1, or store_type=11 SHALL go IDLE->DONE with fault=1 and mem_wr never asserted.
REQ-020 Aligned sw SHALL go IDLE->WRITE with mem_wdata=reg_data, with no memory read.
REQ-021 sh/sb SHALL go IDLE->RD_WAIT and drive mem_addr with mem_wr=0 for READ_WAIT cycles, using a 3-bit counter.
REQ-022 In the final RD_WAIT cycle, mem_rdata SHALL be captured into a merge register; next state is MERGE.
REQ-023 MERGE, little-endian byte lanes: sb replaces byte lane addr_q[1:0] (lane 0 = bits 7:0) with reg_data[7:0].
REQ-024 MERGE: sh replaces bits 15:0 when addr_q[1]=0, else bits 31:16, with reg_data[15:0]; all other bits keep the captured word.
REQ-025 WRITE SHALL assert mem_wr=1 for exactly one cycle with mem_addr and mem_wdata stable, then go to DONE.
REQ-026 DONE SHALL assert done=1 for one cycle (fault as decided), then return to IDLE.
REQ-027 Latency from the start-accept edge to done: sw 2 cycles, sh/sb READ_WAIT+3 cycles, fault 1 cycle.
REQ-028 mem_wdata SHALL hold its last value outside WRITE; mem_wr=0 in every state except WRITE.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE and set busy=0, done=0, fault=0, mem_wr=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-030 Reset mid-operation SHALL abort with no write on or after the reset edge, including from RD_WAIT or MERGE; no done pulse for the aborted store.
REQ-031 The first start is accepted on the first edge with reset=1.

Verification
REQ-032 sw, addr=0x100, reg_data=0xDEADBEEF -> one mem_wr at mem_addr=0x100, mem_wdata=0xDEADBEEF; done 2 cycles after accept; fault=0.
REQ-033 sb, addr=0x102, reg_data=0x000000AB, mem_rdata=0x11223344 -> mem_wdata=0x11AB3344 at 0x100; done 5 cycles after accept (READ_WAIT=2).
REQ-034 sh, addr=0x206, reg_data=0x0000CAFE, mem_rdata=0x55667788 -> mem_wdata=0xCAFE7788 at 0x204; sh at addr=0x201 -> fault=1, no mem_wr, done 1 cycle after accept.
REQ-035 store_type=11 at any addr -> fault=1, no mem_wr; start pulses while busy=1 -> no effect, exactly one done per accepted start.
REQ-036 reset=0 during RD_WAIT of an sb -> mem_wr never asserted, all outputs zero next edge; a fresh sw after reset completes normally.
